// File: rtl/led_out.sv
// rtl/led_out.sv - memory-mapped LED set/clear register with optional blink engine (LED_BLINK_EN)
// Registered readdata and LEDR_out; asynchronous active-low reset clears all state.
module led_out #(
  parameter int unsigned BLINK_DIV = 25000000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        write,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic [9:0]  LEDR_out
);

  localparam logic [31:0] LP_DIV_LAST = 32'(BLINK_DIV - 1);

  logic [9:0]  r_led;
  logic [9:0]  r_ledr;
  logic [31:0] r_rdata;
  logic [9:0]  w_wd;
  logic [9:0]  w_mask;
  logic        w_phase;
  logic [9:0]  w_ledr_next;
  logic [31:0] w_rdata;
  logic        w_unused;

  assign w_wd = writedata[9:0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_led <= '0;
    end else if (write) begin
      case (address)
        2'd0:    r_led <= w_wd;
        2'd1:    r_led <= r_led | w_wd;
        2'd2:    r_led <= r_led & ~w_wd;
        default: r_led <= r_led;
      endcase
    end
  end

`ifdef LED_BLINK_EN
  logic [9:0]  r_mask;
  logic        r_phase;
  logic [31:0] r_div_cnt;

  // A mask write restarts the blink period and wins over a simultaneous wrap.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mask    <= '0;
      r_phase   <= 1'b0;
      r_div_cnt <= '0;
    end else if (write && (address == 2'd3)) begin
      r_mask    <= w_wd;
      r_phase   <= 1'b0;
      r_div_cnt <= '0;
    end else if (r_div_cnt == LP_DIV_LAST) begin
      r_phase   <= ~r_phase;
      r_div_cnt <= '0;
    end else begin
      r_div_cnt <= r_div_cnt + 32'd1;
    end
  end

  assign w_mask      = r_mask;
  assign w_phase     = r_phase;
  assign w_ledr_next = r_led ^ (r_mask & {10{r_phase}});
  assign w_unused    = ^writedata[31:10];
`else
  assign w_mask      = '0;
  assign w_phase     = 1'b0;
  assign w_ledr_next = r_led;
  assign w_unused    = ^{writedata[31:10], LP_DIV_LAST};
`endif

  // Read mux sees pre-write state, so a same-cycle write is not yet visible.
  always_comb begin
    w_rdata = '0;
    case (address)
      2'd0:    w_rdata = {22'b0, r_led};
      2'd1:    w_rdata = {22'b0, r_ledr};
      2'd2:    w_rdata = {31'b0, w_phase};
      default: w_rdata = {22'b0, w_mask};
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ledr  <= '0;
      r_rdata <= '0;
    end else begin
      r_ledr  <= w_ledr_next;
      r_rdata <= w_rdata;
    end
  end

  assign LEDR_out = r_ledr;
  assign readdata = r_rdata;

endmodule

// File: tb/tb_led_out.sv
// tb/tb_led_out.sv - directed self-checking bench for led_out (blink checks when LED_BLINK_EN is defined)
module tb_led_out;

  logic        clk;
  logic        reset_n;
  logic [1:0]  address;
  logic        write;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [9:0]  LEDR_out;

  int n_cmp;
  int n_err;

  led_out #(.BLINK_DIV(4)) u_dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .address   (address),
    .write     (write),
    .writedata (writedata),
    .readdata  (readdata),
    .LEDR_out  (LEDR_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    write     = 1'b1;
    address   = a;
    writedata = d;
    @(negedge clk);
    write     = 1'b0;
    address   = 2'd0;
    writedata = '0;
  endtask

  initial begin
    n_cmp     = 0;
    n_err     = 0;
    reset_n   = 1'b0;
    write     = 1'b0;
    address   = 2'd0;
    writedata = '0;
    repeat (2) @(negedge clk);
    check_eq("rst_ledr", {22'b0, LEDR_out}, 32'h0);
    check_eq("rst_rdata", readdata, 32'h0);
    reset_n = 1'b1;

    // set / or / and-not sequence, LEDR lags led_reg by one edge
    wr(2'd0, 32'h00F);
    check_eq("ledr_lag", {22'b0, LEDR_out}, 32'h0);
    @(negedge clk);
    check_eq("set_ledr", {22'b0, LEDR_out}, 32'h00F);
    check_eq("set_rd", readdata, 32'h00F);
    wr(2'd1, 32'h300);
    check_eq("or_lag", {22'b0, LEDR_out}, 32'h00F);
    @(negedge clk);
    check_eq("or_ledr", {22'b0, LEDR_out}, 32'h30F);
    check_eq("or_rd", readdata, 32'h30F);
    wr(2'd2, 32'h003);
    @(negedge clk);
    check_eq("clr_ledr", {22'b0, LEDR_out}, 32'h30C);
    check_eq("clr_rd", readdata, 32'h30C);
    address = 2'd1;
    @(negedge clk);
    check_eq("rd_addr1", readdata, 32'h30C);
    address = 2'd0;

    // same-cycle read/write collision
    wr(2'd0, 32'h155);
    write     = 1'b1;
    address   = 2'd0;
    writedata = 32'h2AA;
    @(negedge clk);
    check_eq("coll_old", readdata, 32'h155);
    write     = 1'b0;
    writedata = '0;
    @(negedge clk);
    check_eq("coll_new", readdata, 32'h2AA);

    // upper writedata bits ignored
    wr(2'd0, 32'hFFFF_FFFF);
    @(negedge clk);
    check_eq("mask_rd", readdata, 32'h3FF);
    check_eq("mask_ledr", {22'b0, LEDR_out}, 32'h3FF);
    wr(2'd2, 32'hFFFF_FC00);
    @(negedge clk);
    check_eq("hi_clr_noeff", readdata, 32'h3FF);

`ifdef LED_BLINK_EN
    wr(2'd0, 32'h001);
    wr(2'd3, 32'h003);
    address = 2'd2;
    for (int i = 1; i <= 11; i++) begin
      @(negedge clk);
      check_eq("blk_ledr", {22'b0, LEDR_out}, (((i - 1) / 4) % 2) ? 32'h002 : 32'h001);
      check_eq("blk_phase", readdata, 32'(((i - 1) / 4) % 2));
    end
    // mask write lands on a wrap edge: restart must win over toggle
    write     = 1'b1;
    address   = 2'd3;
    writedata = 32'h003;
    @(negedge clk);
    check_eq("blk_mask_rd", readdata, 32'h003);
    check_eq("blk_pre_ledr", {22'b0, LEDR_out}, 32'h001);
    write     = 1'b0;
    writedata = '0;
    address   = 2'd2;
    for (int j = 1; j <= 8; j++) begin
      @(negedge clk);
      check_eq("prio_ledr", {22'b0, LEDR_out}, (((j - 1) / 4) % 2) ? 32'h002 : 32'h001);
      check_eq("prio_phase", readdata, 32'(((j - 1) / 4) % 2));
    end
    address = 2'd0;
`else
    wr(2'd0, 32'h0A5);
    wr(2'd3, 32'h3FF);
    address = 2'd3;
    @(negedge clk);
    check_eq("off_rd3", readdata, 32'h0);
    address = 2'd2;
    @(negedge clk);
    check_eq("off_rd2", readdata, 32'h0);
    address = 2'd0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_eq("off_ledr", {22'b0, LEDR_out}, 32'h0A5);
    end
    check_eq("off_led", readdata, 32'h0A5);
`endif

    // asynchronous reset mid-cycle
    wr(2'd0, 32'h3C3);
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("arst_ledr", {22'b0, LEDR_out}, 32'h0);
    check_eq("arst_rd", readdata, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("rel_ledr", {22'b0, LEDR_out}, 32'h0);
    check_eq("rel_rd", readdata, 32'h0);

    // write issued while reset is held is discarded
    write     = 1'b1;
    address   = 2'd0;
    writedata = 32'h0FF;
    #2;
    reset_n = 1'b0;
    @(negedge clk);
    write     = 1'b0;
    writedata = '0;
    reset_n   = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("rstwr_rd", readdata, 32'h0);
    check_eq("rstwr_ledr", {22'b0, LEDR_out}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/led_out.md
LED_OUT -- requirements
Module: led_out

Interface
REQ-001 Parameter: BLINK_DIV, 25000000, clk cycles per blink half-period, legal range 2 to 2^32-1.
REQ-002 Port: clk  input  1  sole clock, all state updates on rising edge.
REQ-003 Port: reset_n  input  1  asynchronous, active-low reset.
REQ-004 Port: address  input  2  register select.
REQ-005 Port: write  input  1  write strobe, sampled on rising clk.
REQ-006 Port: writedata  input  32  write data, bits [31:10] ignored.
REQ-007 Port: readdata  output  32  registered read data.
REQ-008 Port: LEDR_out  output  10  registered LED drive, 1 = LED on.

Function
REQ-009 The block SHALL hold led_reg[9:0], blink_mask[9:0], blink_phase (1 bit) and a 32-bit divider counter div_cnt.
REQ-010 When write=1 and address=0, led_reg SHALL load writedata[9:0] at that edge.
REQ-011 When write=1 and address=1, led_reg SHALL become led_reg OR writedata[9:0] at that edge.
REQ-012 When write=1 and address=2, led_reg SHALL become led_reg AND NOT writedata[9:0] at that edge.
REQ-013 When write=1 and address=3, blink_mask SHALL load writedata[9:0], and div_cnt and blink_phase SHALL clear to 0 at that edge.
REQ-014 div_cnt SHALL increment every cycle; at div_cnt = BLINK_DIV-1 it SHALL wrap to 0 and blink_phase SHALL toggle at the same edge.
REQ-015 A write to address 3 SHALL take priority over the wrap/toggle in the same cycle.
REQ-016 LEDR_out SHALL register led_reg XOR (blink_mask AND {10{blink_phase}}) every cycle, so a write sampled at edge k is visible on LEDR_out after edge k+1.
REQ-017 readdata SHALL register every cycle, with no read strobe, and SHALL have 1-cycle latency from address.
REQ-018 readdata SHALL be {22'b0, led_reg} for address 0, {22'b0, LEDR_out} for address 1, {31'b0, blink_phase} for address 2, and {22'b0, blink_mask} for address 3.
REQ-019 When a read and a write target the same register in the same cycle, readdata SHALL return the pre-write value.
REQ-020 writedata bits [31:10] SHALL have no effect on any state.

Reset
REQ-021 reset_n=0 SHALL immediately clear, without waiting for clk, led_reg, blink_mask, blink_phase, div_cnt, LEDR_out and readdata to 0.
REQ-022 After reset deasserts, the first update SHALL occur on the next rising clk; div_cnt SHALL start counting from 0.
REQ-023 Reset asserted mid-blink or during a write SHALL discard that write and all blink state.

Configuration
REQ-024 Macro LED_BLINK_EN defined: blink_mask, blink_phase and div_cnt SHALL be implemented as in REQ-013 to REQ-016.
REQ-025 Macro LED_BLINK_EN undefined: no divider logic SHALL exist, writes to address 3 SHALL be ignored, and reads of addresses 2 and 3 SHALL return 0.
REQ-026 Macro LED_BLINK_EN undefined: LEDR_out SHALL register led_reg directly.

Verification
REQ-027 Reset check: hold reset_n=0 mid-cycle -> LEDR_out=0 and readdata=0 without a clock edge; release -> both stay 0.
REQ-028 Set/clear check: write addr0 0x00F, then addr1 0x300, then addr2 0x003 -> led_reg goes 0x00F, 0x30F, 0x30C; LEDR_out follows one cycle later; an addr0 read returns 0x30C.
REQ-029 Blink check (BLINK_DIV=4): led_reg=0x001, write addr3 0x003 -> LEDR_out alternates 0x001/0x002 every 4 cycles; an addr2 read tracks phase.
REQ-030 Same-cycle collision check: read addr0 while writing addr0 0x2AA, with old value 0x155 -> readdata=0x155 that cycle, 0x2AA on the next read.
REQ-031 Masking check: write addr0 0xFFFFFFFF -> led_reg=0x3FF, and readdata[31:10]=0.
REQ-032 Macro-off build: write addr3 0x3FF, then read addr3 -> 0; LEDR_out equals led_reg and never toggles.
